// File: rtl/acumulador_produtos.sv
// Multiply-accumulate back end: requests, collects and sums a programmed number of signed products.
// Build option: define ACUM_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module acumulador_produtos #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10,
    parameter int CNT_W  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_terms,
    input  logic signed [PROD_W-1:0] prod,
    input  logic                     prod_valid,
    output logic                     next_req,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]         term_count,
    output logic                     overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          target_q;
    logic [CNT_W-1:0]          count_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      ovf_q;
    logic                      next_req_q;
    logic                      busy_q;
    logic                      done_q;

    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum_raw;
    logic signed [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]          count_d;
    logic                      add_ovf;

    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign sum_raw  = acc_q + prod_ext;
    assign count_d  = count_q + CNT_W'(1);

    // Signed overflow: operands agree in sign but the sum does not.
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef ACUM_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow the direction follows the (shared) operand sign.
    assign acc_d = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
    assign acc_d = sum_raw;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            next_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            next_req_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        target_q <= num_terms;
                        acc_q    <= '0;
                        count_q  <= '0;
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        if (num_terms == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_WAIT;
                            next_req_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (prod_valid) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (add_ovf) begin
                            ovf_q <= 1'b1;
                        end
                        if (count_d == target_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            next_req_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign next_req   = next_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign acc_out    = acc_q;
    assign term_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_acumulador_produtos.sv
// Scoreboard bench for acumulador_produtos: directed sums plus random sums against an integer model.
module tb_acumulador_produtos;

    localparam int ACC_MAX = 511;
    localparam int ACC_MIN = -512;
`ifdef ACUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              start;
    logic [3:0]        num_terms;
    logic signed [7:0] prod;
    logic              prod_valid;
    logic              next_req;
    logic              busy;
    logic              done;
    logic signed [9:0] acc_out;
    logic [3:0]        term_count;
    logic              overflow;

    acumulador_produtos dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_terms  (num_terms),
        .prod       (prod),
        .prod_valid (prod_valid),
        .next_req   (next_req),
        .busy       (busy),
        .done       (done),
        .acc_out    (acc_out),
        .term_count (term_count),
        .overflow   (overflow)
    );

    typedef struct {
        int acc;
        int cnt;
        int ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_acc = 0;
    int   last_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: plain integer running sum, folded back into the 10-bit range.
    function automatic void model(input int p[$], output int acc, output int ovf);
        acc = 0;
        ovf = 0;
        foreach (p[k]) begin
            acc = acc + p[k];
            if (acc > ACC_MAX) begin
                ovf = 1;
                acc = SAT ? ACC_MAX : acc - 1024;
            end else if (acc < ACC_MIN) begin
                ovf = 1;
                acc = SAT ? ACC_MIN : acc + 1024;
            end
        end
    endfunction

    // Monitor: compares every completed sum against the oldest expected entry.
    int req_cnt   = 0;
    bit prev_done = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            req_cnt   = 0;
            prev_done = 1'b0;
        end else begin
            if (next_req) req_cnt++;
            if (done) begin
                if (prev_done) check("done_one_cycle", 1, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("acc_out", int'(acc_out), e.acc);
                    check("term_count", int'(term_count), e.cnt);
                    check("overflow", int'(overflow), e.ovf);
                    check("busy_at_done", int'(busy), 1);
                    check("next_req_pulses", req_cnt, e.cnt);
                    $display("sum done: terms=%0d acc=%0d ovf=%0d (expected acc=%0d ovf=%0d)",
                             term_count, acc_out, overflow, e.acc, e.ovf);
                end
                req_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic run_sum(input int n, input int prods[$], input int abort_at);
        int   acc_m;
        int   ovf_m;
        int   waited;
        bit   got;
        int   gap;
        exp_t e;
        if (abort_at < 0) begin
            model(prods, acc_m, ovf_m);
            e.acc = acc_m;
            e.cnt = n;
            e.ovf = ovf_m;
            sb_q.push_back(e);
        end
        start      = 1'b1;
        num_terms  = 4'(n);
        prod_valid = 1'($urandom_range(0, 1));
        prod       = 8'($urandom);
        tick();
        start      = 1'b0;
        prod_valid = 1'b0;
        num_terms  = 4'($urandom);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check("rst_acc_out", int'(acc_out), 0);
                check("rst_term_count", int'(term_count), 0);
                check("rst_overflow", int'(overflow), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_next_req", int'(next_req), 0);
                tick();
                tick();
                reset = 1'b1;
                prod_valid = 1'b1;
                prod = 8'sd5;
                tick();
                prod_valid = 1'b0;
                @(negedge clock);
                check("post_rst_acc", int'(acc_out), 0);
                check("post_rst_count", int'(term_count), 0);
                check("post_rst_busy", int'(busy), 0);
                $display("sum aborted by reset after %0d products", i);
                last_acc = 0;
                last_cnt = 0;
                tick();
                return;
            end
            waited = 0;
            got = 1'b0;
            while (!got && waited < 20) begin
                @(negedge clock);
                if (next_req) got = 1'b1;
                waited++;
            end
            if (!got) begin
                check("next_req_timeout", 0, 1);
                return;
            end
            tick();
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                start = 1'($urandom_range(0, 1));
                prod  = 8'($urandom);
                tick();
            end
            start      = 1'b0;
            prod       = 8'(prods[i]);
            prod_valid = 1'b1;
            tick();
            prod_valid = 1'b0;
            prod       = 8'($urandom);
        end
        @(negedge clock);
        check("done_latency", int'(done), 1);
        tick();
        @(negedge clock);
        check("busy_after_done", int'(busy), 0);
        check("done_dropped", int'(done), 0);
        last_acc = acc_m;
        last_cnt = n;
        tick();
    endtask

    task automatic idle_product();
        prod_valid = 1'b1;
        prod = 8'($urandom);
        tick();
        prod_valid = 1'b0;
        @(negedge clock);
        check("idle_hold_acc", int'(acc_out), last_acc);
        check("idle_hold_count", int'(term_count), last_cnt);
        tick();
    endtask

    initial begin
        int q[$];
        int n;
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d expected sums pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int n;
        reset = 1'b0;
        start = 1'b0;
        num_terms = '0;
        prod = '0;
        prod_valid = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check("reset_acc_out", int'(acc_out), 0);
        check("reset_term_count", int'(term_count), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_next_req", int'(next_req), 0);
        tick();
        reset = 1'b1;
        tick();

        q.delete(); q.push_back(12); q.push_back(-15); q.push_back(20);
        run_sum(3, q, -1);
        idle_product();

        q.delete();
        run_sum(0, q, -1);

        q.delete(); repeat (10) q.push_back(64);
        run_sum(10, q, -1);

        q.delete(); repeat (10) q.push_back(-56);
        run_sum(10, q, -1);

        q.delete(); q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(4);
        run_sum(4, q, 2);

        idle_product();
        q.delete(); q.push_back(3); q.push_back(4);
        run_sum(2, q, -1);
        idle_product();

        for (int s = 0; s < 30; s++) begin
            n = $urandom_range(0, 15);
            q.delete();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0)
                    q.push_back(($urandom_range(0, 1) != 0) ? 127 : -128);
                else
                    q.push_back(int'($urandom_range(0, 255)) - 128);
            end
            run_sum(n, q, -1);
            if ($urandom_range(0, 2) == 0) idle_product();
        end

        repeat (3) tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
